// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and chunk-index sizing for the serial subtract/compare unit
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_sub_compare_if.sv
// serial_sub_compare_if: operand/result valid-ready bus of the serial subtract/compare unit
interface serial_sub_compare_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             eq;
  logic             carry;
  logic             ovf;
  logic             neg;
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, diff, lt, eq, carry, ovf, neg
  );
  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, diff, lt, eq, carry, ovf, neg
  );
endinterface

// File: rtl/sub_slice.sv
// sub_slice: combinational CHUNK-bit ripple adder used as the shared subtract slice
module sub_slice #(parameter int CHUNK = 4) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_inv,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_inv[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b_inv[i]) | (w_c[i] & (a[i] ^ b_inv[i]));
  end
  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];
endmodule

// File: rtl/serial_sub_compare.sv
// serial_sub_compare: multi-cycle a-b over WIDTH bits, CHUNK bits per clock, with signed/unsigned flags
module serial_sub_compare
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_sub_compare_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW = idx_width(NCHUNK);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b_inv, r_diff, w_diff;
  logic [IW-1:0]    r_idx;
  logic             r_mode, r_c, r_lt, r_eq, r_cf, r_ovf, r_neg;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout, w_c_msb, w_last, w_ovf, w_neg;
  int               w_sh;
  assign w_sh   = int'(r_idx) * CHUNK;
  assign w_last = r_idx == IW'(NCHUNK - 1);
  sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (CHUNK'(r_a >> w_sh)),
    .b_inv    (CHUNK'(r_b_inv >> w_sh)),
    .cin      (r_c),
    .sum      (w_sum),
    .cout     (w_cout),
    .c_msb_in (w_c_msb)
  );
  // current chunk merged into the running difference so flags see the complete value
  assign w_diff = (r_diff & ~(MASK << w_sh)) | (WIDTH'(w_sum) << w_sh);
  assign w_ovf  = w_c_msb ^ w_cout;
  assign w_neg  = w_diff[WIDTH-1];
  always_comb begin
    w_next        = IDLE;
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    w_next = (r_state == IDLE) ? (bus.in_valid ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) :
             (r_state == DONE && !bus.out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b_inv <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_c     <= 1'b1;
      r_diff  <= '0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_cf    <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_a     <= bus.a;
        r_b_inv <= ~bus.b;
        r_mode  <= bus.signed_mode;
        r_idx   <= '0;
        r_c     <= 1'b1;
      end else if (r_state == RUN) begin
        r_diff <= w_diff;
        r_c    <= w_cout;
        r_idx  <= r_idx + 1'b1;
        if (w_last) begin
          r_neg <= w_neg;
          r_ovf <= w_ovf;
          r_cf  <= w_cout;
          r_eq  <= w_diff == '0;
          r_lt  <= r_mode ? (w_neg ^ w_ovf) : ~w_cout;
        end
      end
    end
  end
  assign bus.diff  = r_diff;
  assign bus.lt    = r_lt;
  assign bus.eq    = r_eq;
  assign bus.carry = r_cf;
  assign bus.ovf   = r_ovf;
  assign bus.neg   = r_neg;
endmodule

// File: tb/tb_serial_sub_compare.sv
// tb_serial_sub_compare: directed and randomized checks of serial_sub_compare against an arithmetic model
module tb_serial_sub_compare;
  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  serial_sub_compare_if #(.WIDTH(W)) bus ();
  serial_sub_compare #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] pick();
    logic [W-1:0] t [5];
    t = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
    return ($urandom_range(0, 3) == 0) ? t[$urandom_range(0, 4)] : W'($urandom);
  endfunction
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                    input int hold, input string tag);
    logic [W-1:0] d;
    logic         c, ov, lt, eq, ng;
    int           lat;
    d  = a - b;
    c  = a >= b;
    eq = a == b;
    ng = d[W-1];
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    lt = m ? ($signed(a) < $signed(b)) : (a < b);
    chk({tag, ":in_ready"}, 32'(bus.in_ready), 1);
    bus.a = a; bus.b = b; bus.signed_mode = m; bus.in_valid = 1'b1;
    bus.out_ready = 1'(($urandom));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.signed_mode = 1'($urandom);
    chk({tag, ":busy"}, 32'(bus.in_ready), 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid) bus.out_ready = 1'($urandom);
    end
    chk({tag, ":latency"}, 32'(lat), 32'(N));
    chk({tag, ":diff"}, 32'(bus.diff), 32'(d));
    chk({tag, ":flags lt,eq,c,ovf,neg"}, {bus.lt, bus.eq, bus.carry, bus.ovf, bus.neg},
        {lt, eq, c, ov, ng});
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
      @(posedge clk); #1;
      chk({tag, ":hold"}, {bus.out_valid, bus.in_ready, bus.diff, bus.lt, bus.eq, bus.carry, bus.ovf, bus.neg},
          {1'b1, 1'b0, d, lt, eq, c, ov, ng});
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":release"}, {bus.out_valid, bus.in_ready}, 2'b01);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    int seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    #12;
    chk("reset", {bus.in_ready, bus.out_valid, bus.diff, bus.lt, bus.eq, bus.carry, bus.ovf, bus.neg},
        {1'b1, 1'b0, 16'h0, 5'b0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(16'h0005, 16'h0003, 1'b0, 0, "u5-3");
    op(16'h8000, 16'h0001, 1'b1, 0, "smin-1");
    op(16'h1234, 16'h1234, 1'b0, 1, "eq_u");
    op(16'h1234, 16'h1234, 1'b1, 0, "eq_s");
    op(16'h0003, 16'hFFFF, 1'b0, 0, "u3-ffff");
    op(16'h0003, 16'hFFFF, 1'b1, 0, "s3-m1");
    op(16'h7FFF, 16'h8000, 1'b1, 5, "backpressure");
    bus.a = 16'h1234; bus.b = 16'h0001; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {bus.in_ready, bus.out_valid, bus.diff, bus.lt, bus.eq, bus.carry, bus.ovf, bus.neg},
        {1'b1, 1'b0, 16'h0, 5'b0});
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("aborted_no_result", 32'(seen), 0);
    op(16'hFFFF, 16'h0000, 1'b0, 0, "after_reset");
    for (int i = 0; i < 40; i++) op(pick(), pick(), 1'($urandom), $urandom_range(0, 3), "rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_sub_compare.md
Name: serial_sub_compare

Overview:
- Parametrised, multi-cycle two's-complement subtract/compare unit; next generation of the team's 4-bit signed less-than subtractor.
- Computes a − b as a + ~b + 1 over WIDTH bits, CHUNK bits per clock, through one shared ripple slice.
- Adds a selectable signed/unsigned mode, a full flag set (lt, eq, carry, overflow, negative) and the difference itself.
- Sits between operand producers and branch/sort logic, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand and difference width; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits processed per cycle; NCHUNK = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- signed_mode  in  1  1 = signed compare, 0 = unsigned compare.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a − b modulo 2^WIDTH.
- lt  out  1  a < b under the latched mode.
- eq  out  1  a == b.
- carry  out  1  final carry out; 1 means no unsigned borrow (a >= b unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- neg  out  1  diff[WIDTH-1].

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=1; out_valid=0; diff, lt, eq, carry, ovf, neg = 0; internal chunk index = 0; carry register = 1. Reset takes effect immediately, including mid-RUN or in DONE; any operation in progress is discarded with no output.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, ~b and signed_mode; set idx=0 and carry=1; go to RUN.
  - RUN: each cycle, the slice adds a_chunk[idx] + ~b_chunk[idx] + carry. It writes diff bits [idx*CHUNK +: CHUNK], updates carry, and records the carry into the MSB while idx = NCHUNK−1. idx increments. After the chunk at idx = NCHUNK−1, go to DONE. in_ready=0.
  - DONE: out_valid=1 and all outputs stable. On out_ready, go to IDLE; out_valid falls on the next cycle. in_ready=0 in DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (4 for defaults). Throughput is one operation per NCHUNK+2 cycles when out_ready is held high.
- Flags, registered on entry to DONE:
  - neg = diff MSB.
  - ovf = c_msb_in ^ carry.
  - eq = (diff == 0).
  - lt = signed_mode ? (neg ^ ovf) : ~carry.
- Operand changes on a, b and signed_mode while not in IDLE have no effect.
- in_valid with in_ready=0 is ignored; the producer holds its data.
- out_ready in IDLE or RUN is ignored.
- Operands at the limits (most negative value, all ones, zero) need no special case; the arithmetic is purely modular.

Decomposition:
- Package serial_sub_pkg: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the NCHUNK/index-width derivation (clog2 of NCHUNK, minimum 1).
- Sub-module sub_slice:
  - parameter CHUNK; purely combinational ripple of full-adder cells.
  - Inputs: a, b_inv, cin. Outputs: sum, cout, c_msb_in (carry into the slice's top bit).
  - Instantiated once in serial_sub_compare.

Test Plan (defaults WIDTH=16, CHUNK=4):
- Unsigned, a=0x0005, b=0x0003 -> after 4 cycles out_valid=1; diff=0x0002, carry=1, lt=0, eq=0, ovf=0, neg=0.
- Signed, a=0x8000, b=0x0001 -> diff=0x7FFF, neg=0, ovf=1, lt=1, carry=1.
- a=b=0x1234, both modes -> diff=0x0000, eq=1, lt=0, carry=1.
- a=0x0003, b=0xFFFF:
  - unsigned -> diff=0x0004, carry=0, lt=1.
  - signed (3 − (−1)) -> diff=0x0004, lt=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle, in_ready=1, next operand accepted.
- Reset mid-RUN: assert rst_n=0 during the cycle with idx=2 -> outputs and out_valid go to 0 asynchronously. After release, in_ready=1, and no result appears for the aborted operation.
